// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and run-control outputs shared between the stopwatch controller
// and its environment.
interface stopwatch_ctrl_if;
    logic       btn_start_stop;
    logic       btn_lap_reset;
    logic       run;
    logic       tick;
    logic       clear;
    logic       lap_hold;
    logic [1:0] state;

    modport master (
        output btn_start_stop,
        output btn_lap_reset,
        input  run,
        input  tick,
        input  clear,
        input  lap_hold,
        input  state
    );

    modport slave (
        input  btn_start_stop,
        input  btn_lap_reset,
        output run,
        output tick,
        output clear,
        output lap_hold,
        output state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: button sync/debounce, run-control FSM and the
// count-enable prescaler feeding the BCD counter chain.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned DCW = $clog2(DB_CYCLES);
    localparam int unsigned PCW = $clog2(TICK_DIV);
    localparam logic [DCW-1:0] DB_MAX = DCW'(DB_CYCLES - 1);
    localparam logic [PCW-1:0] PC_MAX = PCW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        LAP    = 2'b10,
        PAUSED = 2'b11
    } state_t;

    // Index 0 is start/stop, index 1 is lap/reset.
    logic [1:0]     btn_raw;
    logic [1:0]     s1;
    logic [1:0]     s2;
    logic [1:0]     db;
    logic [DCW-1:0] dc [2];
    logic [1:0]     press;

    state_t         state_q;
    state_t         state_d;
    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_d;
    logic           clear_d;
    logic           tick_d;
    logic           run_d;
    logic           hold_d;

    assign btn_raw = {bus.btn_lap_reset, bus.btn_start_stop};

    // Synchronizers and debounce counters for both buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            dc[0] <= '0;
            dc[1] <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DB_MAX) begin
                    db[i] <= ~db[i];
                    dc[i] <= '0;
                end else begin
                    dc[i] <= dc[i] + DCW'(1);
                end
            end
        end
    end

    // A press is the debounced level about to rise; releases are ignored.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++) begin
            press[i] = s2[i] & ~db[i] & (dc[i] == DB_MAX);
        end
    end

    // Next-state, clear and prescaler decisions; start/stop beats lap/reset.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        pc_d    = pc_q;
        tick_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (press[0]) begin
                    state_d = RUN;
                end else if (press[1]) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            RUN: begin
                if (press[0]) begin
                    state_d = PAUSED;
                end else if (press[1]) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (press[0]) begin
                    state_d = PAUSED;
                end else if (press[1]) begin
                    state_d = RUN;
                end
            end
            PAUSED: begin
                if (press[0]) begin
                    state_d = RUN;
                end else if (press[1]) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Prescaler advances on the current run status; PAUSED keeps the partial second.
        if (clear_d || (state_q == IDLE)) begin
            pc_d = '0;
        end else if ((state_q == RUN) || (state_q == LAP)) begin
            if (pc_q == PC_MAX) begin
                pc_d   = '0;
                tick_d = 1'b1;
            end else begin
                pc_d = pc_q + PCW'(1);
            end
        end

        run_d  = (state_d == RUN) || (state_d == LAP);
        hold_d = (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            bus.run      <= 1'b0;
            bus.tick     <= 1'b0;
            bus.clear    <= 1'b0;
            bus.lap_hold <= 1'b0;
            bus.state    <= 2'b00;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bus.run      <= run_d;
            bus.tick     <= tick_d;
            bus.clear    <= clear_d;
            bus.lap_hold <= hold_d;
            bus.state    <= 2'(state_d);
        end
    end

endmodule
